// File: rtl/booth_step_controller.sv
// Booth radix-2 step sequencer: captures a signed multiplier and issues one
// add/subtract step per clock to the downstream shift-and-add datapath.
module booth_step_controller #(
    parameter int WIDTH   = 4,
    parameter int SHIFT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   b_in,
    output logic               load,
    output logic               busy,
    output logic               op,
    output logic [SHIFT_W-1:0] a_shift_amount,
    output logic [SHIFT_W-1:0] b_shift_amount,
    output logic               done,
    output logic [SHIFT_W-1:0] step_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic               load_q, load_d;
    logic               busy_q, busy_d;
    logic               op_q, op_d;
    logic [SHIFT_W-1:0] a_shift_q, a_shift_d;
    logic [SHIFT_W-1:0] b_shift_q, b_shift_d;
    logic               done_q, done_d;
    logic [SHIFT_W-1:0] step_count_q, step_count_d;
    logic [WIDTH-1:0]   b_reg_q, b_reg_d;
    logic [WIDTH-1:0]   pending_q, pending_d;
    logic [SHIFT_W-1:0] prev_q, prev_d;

    logic               step_found;
    logic [SHIFT_W-1:0] step_k;
    logic               step_op;
    logic [WIDTH-1:0]   step_mask;
    logic [WIDTH-1:0]   recode;

    assign recode = b_in ^ {b_in[WIDTH-2:0], 1'b0};

    // Lowest remaining boundary of a run of equal bits is the next step.
    always_comb begin
        step_found = 1'b0;
        step_k     = '0;
        step_op    = 1'b0;
        step_mask  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!step_found && pending_q[i]) begin
                step_found   = 1'b1;
                step_k       = SHIFT_W'(i);
                step_op      = ~b_reg_q[i];
                step_mask[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        load_d       = 1'b0;
        busy_d       = busy_q;
        op_d         = op_q;
        a_shift_d    = a_shift_q;
        b_shift_d    = b_shift_q;
        done_d       = 1'b1;
        step_count_d = step_count_q;
        b_reg_d      = b_reg_q;
        pending_d    = pending_q;
        prev_d       = prev_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    b_reg_d      = b_in;
                    pending_d    = recode;
                    prev_d       = '0;
                    step_count_d = '0;
                    load_d       = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = LOAD;
                end
            end
            LOAD, RUN: begin
                if (!step_found) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    op_d         = step_op;
                    a_shift_d    = step_k;
                    b_shift_d    = step_k - prev_q;
                    done_d       = 1'b0;
                    pending_d    = pending_q & ~step_mask;
                    prev_d       = step_k;
                    step_count_d = step_count_q + SHIFT_W'(1);
                    busy_d       = 1'b1;
                    state_d      = RUN;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            load_q       <= 1'b0;
            busy_q       <= 1'b0;
            op_q         <= 1'b0;
            a_shift_q    <= '0;
            b_shift_q    <= '0;
            done_q       <= 1'b1;
            step_count_q <= '0;
            b_reg_q      <= '0;
            pending_q    <= '0;
            prev_q       <= '0;
        end else begin
            state_q      <= state_d;
            load_q       <= load_d;
            busy_q       <= busy_d;
            op_q         <= op_d;
            a_shift_q    <= a_shift_d;
            b_shift_q    <= b_shift_d;
            done_q       <= done_d;
            step_count_q <= step_count_d;
            b_reg_q      <= b_reg_d;
            pending_q    <= pending_d;
            prev_q       <= prev_d;
        end
    end

    assign load           = load_q;
    assign busy           = busy_q;
    assign op             = op_q;
    assign a_shift_amount = a_shift_q;
    assign b_shift_amount = b_shift_q;
    assign done           = done_q;
    assign step_count     = step_count_q;

endmodule

// File: tb/tb_booth_step_controller.sv
// Bench for booth_step_controller: expected step lists come from the run
// boundaries of the multiplier, and the issued steps must rebuild A*B.
module tb_booth_step_controller;

    localparam int WIDTH   = 4;
    localparam int SHIFT_W = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [WIDTH-1:0]   b_in = '0;
    logic               load;
    logic               busy;
    logic               op;
    logic [SHIFT_W-1:0] a_shift_amount;
    logic [SHIFT_W-1:0] b_shift_amount;
    logic               done;
    logic [SHIFT_W-1:0] step_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit op;
        int k;
        int rel;
    } step_t;

    booth_step_controller #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .b_in           (b_in),
        .load           (load),
        .busy           (busy),
        .op             (op),
        .a_shift_amount (a_shift_amount),
        .b_shift_amount (b_shift_amount),
        .done           (done),
        .step_count     (step_count)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic st, input logic [WIDTH-1:0] b);
        start = st;
        b_in  = b;
    endtask

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One step per boundary between differing adjacent bits (b[-1] = 0).
    function automatic void buildSteps(input logic [WIDTH-1:0] b, ref step_t q[$]);
        int prevBit = 0;
        int prevK   = 0;
        q.delete();
        for (int k = 0; k < WIDTH; k++) begin
            int bitK = int'(b[k]);
            if (bitK != prevBit) begin
                step_t s;
                s.op  = (bitK == 0);
                s.k   = k;
                s.rel = k - prevK;
                q.push_back(s);
                prevK = k;
            end
            prevBit = bitK;
        end
    endfunction

    function automatic int toSigned(input logic [WIDTH-1:0] b);
        return b[WIDTH-1] ? int'(b) - (1 << WIDTH) : int'(b);
    endfunction

    // Runs one operation starting at a negedge with the DUT idle.
    task automatic runOp(input logic [WIDTH-1:0] b, input int a, input bit hold,
                         input bit poke);
        step_t q[$];
        int acc = 0;
        buildSteps(b, q);
        applyStimulus(1'b1, b);
        @(negedge clk);
        if (!hold) applyStimulus(1'b0, b);
        checkOutput("load_pulse", 32'(load), 1);
        checkOutput("load_busy", 32'(busy), 1);
        checkOutput("load_done", 32'(done), 1);
        checkOutput("load_count", 32'(step_count), 0);
        for (int i = 0; i < q.size(); i++) begin
            if (poke && i == 1) applyStimulus(1'b1, ~b);
            if (poke && i == 2) applyStimulus(1'b0, b);
            @(negedge clk);
            checkOutput("step_done", 32'(done), 0);
            checkOutput("step_busy", 32'(busy), 1);
            checkOutput("step_load", 32'(load), 0);
            checkOutput("step_op", 32'(op), 32'(q[i].op));
            checkOutput("step_a_shift", 32'(a_shift_amount), q[i].k);
            checkOutput("step_b_shift", 32'(b_shift_amount), q[i].rel);
            checkOutput("step_count", 32'(step_count), i + 1);
            if (op) acc += a <<< int'(a_shift_amount);
            else    acc -= a <<< int'(a_shift_amount);
        end
        if (poke) applyStimulus(1'b0, b);
        @(negedge clk);
        checkOutput("end_done", 32'(done), 1);
        checkOutput("end_busy", 32'(busy), 0);
        checkOutput("end_load", 32'(load), 0);
        checkOutput("end_count", 32'(step_count), q.size());
        checkOutput("product", acc, a * toSigned(b));
    endtask

    initial begin
        applyStimulus(1'b0, '0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_load", 32'(load), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 1);
        checkOutput("rst_op", 32'(op), 0);
        checkOutput("rst_a_shift", 32'(a_shift_amount), 0);
        checkOutput("rst_b_shift", 32'(b_shift_amount), 0);
        checkOutput("rst_count", 32'(step_count), 0);
        rst = 1'b0;
        @(negedge clk);

        runOp(4'b0110, 3, 1'b0, 1'b0);
        runOp(4'b0101, -2, 1'b0, 1'b0);
        runOp(4'b1111, 5, 1'b0, 1'b0);
        runOp(4'b1000, -3, 1'b0, 1'b0);
        runOp(4'b0000, 7, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("zero_idle_done", 32'(done), 1);

        runOp(4'b0101, 6, 1'b0, 1'b1);

        // Reset during the second RUN cycle abandons the operation.
        applyStimulus(1'b1, 4'b0101);
        @(negedge clk);
        applyStimulus(1'b0, 4'b0101);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_done", 32'(done), 1);
        checkOutput("midrst_busy", 32'(busy), 0);
        checkOutput("midrst_load", 32'(load), 0);
        checkOutput("midrst_count", 32'(step_count), 0);
        checkOutput("midrst_a_shift", 32'(a_shift_amount), 0);
        @(negedge clk);
        checkOutput("midrst_idle", 32'(busy), 0);

        runOp(4'b0110, 3, 1'b1, 1'b0);
        runOp(4'b0110, 3, 1'b1, 1'b0);
        runOp(4'b0110, 3, 1'b0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            logic [WIDTH-1:0] rb;
            int ra;
            rb = WIDTH'($urandom_range(0, 15));
            ra = int'($urandom_range(0, 15)) - 8;
            runOp(rb, ra, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/booth_step_controller.md
Name: booth_step_controller

Overview:
- Control stage that drives the shift-and-add multiplier datapath, which sits directly downstream.
- Captures a signed multiplier operand on a start request and Booth-recodes it (radix-2, skipping runs of equal bits).
- Issues one add/subtract step per clock: op, absolute A shift, relative B shift and an active-low-accumulate done flag.
- Issues a one-cycle load pulse so the datapath captures its operands and clears its accumulator before stepping.

Parameters:
WIDTH, 4, operand width in bits (signed two's complement)
SHIFT_W, 3, width of shift-amount outputs; must satisfy 2**SHIFT_W > WIDTH

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request a multiplication; sampled only in IDLE
b_in  input  WIDTH  multiplier operand; captured on the cycle start is accepted
load  output  1  one-cycle pulse; datapath captures operands and clears accumulator
busy  output  1  high in LOAD and RUN
op  output  1  1 = add shifted A, 0 = subtract shifted A
a_shift_amount  output  SHIFT_W  absolute bit position k of current step
b_shift_amount  output  SHIFT_W  k minus position of previous step (first step: k)
done  output  1  low only while a valid step is presented; datapath accumulates when low
step_count  output  SHIFT_W  number of steps issued since last load

Behaviour:
- Single clock; synchronous active-high reset. All outputs are registered.
- Reset values: state IDLE, load=0, busy=0, op=0, a_shift_amount=0, b_shift_amount=0, done=1, step_count=0, internal b_reg=0, pending=0, prev=0.
- Recode vector: r[i] = b[i] XOR b[i-1] for i = 0..WIDTH-1, with b[-1] = 0. The top run is never closed; this is correct for signed operands.
- Step at position k: op = NOT b[k]. Bit 1 over 0 means subtract A<<k; bit 0 over 1 means add A<<k.
- IDLE:
  - done=1, busy=0, load=0.
  - If start=1: b_reg <= b_in, pending <= r(b_in), prev <= 0, step_count <= 0, go to LOAD.
- LOAD (exactly 1 cycle):
  - load=1, busy=1, done=1.
  - If pending==0, go to IDLE; the product is 0 and no steps are issued.
  - Otherwise go to RUN.
- RUN (one cycle per set bit of pending):
  - k = index of the lowest set bit of pending.
  - Present op = ~b_reg[k], a_shift_amount = k, b_shift_amount = k - prev, done=0.
  - Update: clear pending[k], prev <= k, step_count += 1.
  - When the step just presented clears the last set bit, next cycle goes to IDLE with done=1.
- Latency from start accepted to done returning high: 2 + popcount(r) cycles. Maximum is WIDTH+2.
- start while busy is ignored, with no queuing. start held high in IDLE re-triggers on the cycle after returning to IDLE.
- rst asserted in any state, including mid-RUN: next edge forces reset values. done=1 immediately prevents further accumulation; any partial product is abandoned.
- Outputs op, a_shift_amount and b_shift_amount hold their last values while done=1. The consumer must ignore them.
- Widths: the b_shift_amount subtraction is unsigned and never negative, because steps are issued in ascending k.

Test Plan:
- rst high 2 cycles → load=0, busy=0, done=1, all shift outputs 0, step_count=0.
- start with b_in=4'b0110 (6) → LOAD pulse, then steps (op=0,a=1,b=1), (op=1,a=3,b=2), then done=1. Datapath with A=3 yields acc=18.
- start with b_in=4'b0101 (5) → 4 steps: (0,0,0), (1,1,1), (0,2,1), (1,3,1). step_count ends at 4. A=-2 gives acc=-10 (8'hF6).
- b_in=4'b1111 → single step (op=0,a=0,b=0), giving acc=-A. b_in=4'b1000 → single step (op=0,a=3,b=3). b_in=0 → LOAD then IDLE, done never low.
- start pulsed again during RUN → ignored, step sequence unchanged. rst asserted on the 2nd RUN cycle → next cycle IDLE, done=1, busy=0.
- start held high continuously with b_in=4'b0110 → back-to-back operations, each beginning with a load pulse one cycle after returning to IDLE.
